io_input_conditioner: RTL and testbench
=======================================

Name: io_input_conditioner

Overview:
- Upstream neighbour of the load-store unit's input-peripheral region.
- Takes raw asynchronous board switches and push-buttons, then synchronises and debounces them.
- Also generates sticky button-press event flags.
- Drives the two 32-bit words that the LSU samples into its input memory: switch word at offset 0x00, button byte at offset 0x10.

Parameters:
- SW_W, 18, number of physical switches; legal range 1..32.
- BTN_W, 4, number of physical buttons; legal range 1..4, because level and event bits share one byte.
- DEBOUNCE_CYCLES, 500000, number of consecutive stable cycles required before a new level is accepted (10 ms at 50 MHz); must be ≥ 2.
- BTN_ACTIVE_LOW, 1, when 1 the raw buttons read 0 when pressed and are inverted internally.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_sw_raw  input  SW_W  raw switch pins, asynchronous to i_clk.
- i_btn_raw  input  BTN_W  raw button pins, asynchronous to i_clk.
- i_evt_clr  input  BTN_W  per-button one-cycle clear of the press-event flag.
- o_io_sw  output  32  debounced switches, zero-extended; connects to the LSU switch input.
- o_io_btn  output  32  button word, connects to the LSU button input:
  - [3:0] debounced pressed level, 1 = pressed;
  - [7:4] sticky press events;
  - [31:8] = 0.
  - Bits at or above BTN_W inside each nibble are 0.

Behaviour:
- Reset is i_rst_n, asynchronous, active-low; clock is i_clk. All flops are reset asynchronously.
- Values forced while i_rst_n is low:
  - Switch synchroniser stages are 0.
  - Button synchroniser stages hold the "released" raw value: 1 when BTN_ACTIVE_LOW=1, else 0.
  - All debounce counters are 0.
  - Stable levels are 0, giving o_io_sw = 0.
  - Event flags are 0, giving o_io_btn = 0.
- Reset asserted mid-debounce abandons the count; there is no partial state after release of reset.
- Synchroniser:
  - Two-flop chain per bit (s1, then s2).
  - Button polarity inversion is applied after s2.
- Debounce, per bit, each independent. Each bit has a counter of width $clog2(DEBOUNCE_CYCLES) and a stable flop. On every rising edge:
  - If s2 == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0.
  - Else: counter <= counter+1.
- Latency: let edge k be the first edge at which s1 captures the new raw value.
  - s2 differs from stable after edge k+1.
  - stable updates at edge k+1+DEBOUNCE_CYCLES.
  - This assumes the raw value is held throughout.
- Glitch rejection: any return to the old value before the count completes resets the counter. No output change occurs.
- Outputs are driven directly from the stable flops, with no extra register stage. They change exactly at the update edge.
- Press event flag per button:
  - Set on the edge where the debounced level goes 0→1.
  - Cleared on an edge where i_evt_clr[i]=1.
  - If set and clear happen on the same edge, set wins and the flag ends at 1.
  - A release (1→0) has no effect on the flag.
  - Holding a button sets the flag only once.
- Unused upper bits of o_io_sw and o_io_btn are constant 0.

Test Plan:
1. Reset release: reset with i_btn_raw=4'hF (active-low, released) and i_sw_raw=0 -> o_io_sw=0 and o_io_btn=0 for 20 cycles after reset release.
2. Switch debounce latency: DEBOUNCE_CYCLES=4; i_sw_raw=18'h2A5A5 is captured at edge k and then held -> o_io_sw=32'h0002A5A5 exactly after edge k+5 and not earlier.
3. Glitch rejection: DEBOUNCE_CYCLES=4; pulse i_sw_raw[0]=1 for 3 cycles, then return to 0 -> o_io_sw stays 0 throughout.
4. Button press:
   - DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1; drive i_btn_raw=4'b1101 -> o_io_btn=32'h22 after debounce.
   - Hold for 50 cycles -> value stays 32'h22.
   - Release to 4'hF -> o_io_btn=32'h20, because the event stays sticky.
5. Event clear and set priority:
   - With flag[1]=1, pulse i_evt_clr=4'b0010 -> o_io_btn[5]=0 next cycle.
   - Re-press button 1 and align i_evt_clr[1]=1 with the debounced 0→1 edge -> o_io_btn[5]=1.
6. Mid-debounce reset: assert i_rst_n low asynchronously, between clock edges, 2 cycles into a 4-cycle count on switch 3 -> o_io_sw drops to 0 immediately.
   - Release reset with the raw value still high -> the full DEBOUNCE_CYCLES+2 cycle latency is required before o_io_sw=32'h8.

Source files
------------

// File: rtl/io_input_conditioner.sv
// Board switch/button front end: two-flop synchronisers, per-bit counter debounce,
// and sticky press-event flags, packed into the two words the LSU input region samples.
module io_input_conditioner #(
   parameter int SW_W            = 18,
   parameter int BTN_W           = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [SW_W-1:0]  i_sw_raw,
   input  logic [BTN_W-1:0] i_btn_raw,
   input  logic [BTN_W-1:0] i_evt_clr,
   output logic [31:0]      o_io_sw,
   output logic [31:0]      o_io_btn
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BTN_W-1:0] BTN_IDLE = {BTN_W{BTN_ACTIVE_LOW}};

   logic [SW_W-1:0]  r_sw_s1;
   logic [SW_W-1:0]  r_sw_s2;
   logic [BTN_W-1:0] r_btn_s1;
   logic [BTN_W-1:0] r_btn_s2;
   logic [BTN_W-1:0] w_btn_lvl;
   logic [SW_W-1:0]  r_sw_stable;
   logic [BTN_W-1:0] r_btn_stable;
   logic [BTN_W-1:0] r_btn_evt;
   logic [BTN_W-1:0] w_btn_rise;

   // Button chains idle at the released pin level so reset release never looks like a press.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sw_s1  <= '0;
         r_sw_s2  <= '0;
         r_btn_s1 <= BTN_IDLE;
         r_btn_s2 <= BTN_IDLE;
      end else begin
         r_sw_s1  <= i_sw_raw;
         r_sw_s2  <= r_sw_s1;
         r_btn_s1 <= i_btn_raw;
         r_btn_s2 <= r_btn_s1;
      end
   end

   assign w_btn_lvl = BTN_ACTIVE_LOW ? ~r_btn_s2 : r_btn_s2;

   for (genvar i = 0; i < SW_W; i++) begin : g_sw_db
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_cnt          <= '0;
            r_sw_stable[i] <= 1'b0;
         end else if (r_sw_s2[i] == r_sw_stable[i]) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_sw_stable[i] <= r_sw_s2[i];
            r_cnt          <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < BTN_W; i++) begin : g_btn_db
      logic [CNT_W-1:0] r_cnt;

      // A press is the exact edge on which the debounced level accepts a 1.
      assign w_btn_rise[i] = w_btn_lvl[i] & ~r_btn_stable[i] & (r_cnt == CNT_MAX);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_cnt           <= '0;
            r_btn_stable[i] <= 1'b0;
         end else if (w_btn_lvl[i] == r_btn_stable[i]) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_MAX) begin
            r_btn_stable[i] <= w_btn_lvl[i];
            r_cnt           <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end

      // Set beats a coincident clear so a press landing on a clear is never lost.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            r_btn_evt[i] <= 1'b0;
         end else if (w_btn_rise[i]) begin
            r_btn_evt[i] <= 1'b1;
         end else if (i_evt_clr[i]) begin
            r_btn_evt[i] <= 1'b0;
         end
      end
   end

   assign o_io_sw = 32'(r_sw_stable);

   always_comb begin
      o_io_btn              = '0;
      o_io_btn[BTN_W-1:0]   = r_btn_stable;
      o_io_btn[4 +: BTN_W]  = r_btn_evt;
   end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised and directed bench for io_input_conditioner with a timestamp-based
// debounce reference model running alongside the DUT.
module tb_io_input_conditioner;

   localparam int SW_W  = 18;
   localparam int BTN_W = 4;
   localparam int DC    = 4;

   logic             clk;
   logic             rst_n;
   logic [SW_W-1:0]  sw_raw;
   logic [BTN_W-1:0] btn_raw;
   logic [BTN_W-1:0] evt_clr;
   logic [31:0]      io_sw;
   logic [31:0]      io_btn;

   int checks = 0;
   int errors = 0;

   io_input_conditioner #(
      .SW_W(SW_W), .BTN_W(BTN_W), .DEBOUNCE_CYCLES(DC), .BTN_ACTIVE_LOW(1'b1)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
      .i_evt_clr(evt_clr), .o_io_sw(io_sw), .o_io_btn(io_btn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: raw samples pass through a 2-entry delay queue; a bit's new level is
   // accepted once the delayed value has disagreed with the accepted level for DC edges in a row.
   logic [SW_W-1:0]  m_sw_q[$];
   logic [BTN_W-1:0] m_btn_q[$];
   logic [SW_W-1:0]  m_sw_stable;
   logic [BTN_W-1:0] m_btn_stable;
   logic [BTN_W-1:0] m_evt;
   int               m_sw_run[SW_W];
   int               m_btn_run[BTN_W];
   int               m_edge;
   logic [31:0]      m_exp_sw;
   logic [31:0]      m_exp_btn;

   always @(posedge clk or negedge rst_n) begin : model
      logic [SW_W-1:0]  sw_d;
      logic [BTN_W-1:0] btn_d;
      logic [BTN_W-1:0] prev;
      if (!rst_n) begin
         m_sw_q.delete();
         m_btn_q.delete();
         repeat (2) begin
            m_sw_q.push_back('0);
            m_btn_q.push_back('1);
         end
         m_sw_stable  = '0;
         m_btn_stable = '0;
         m_evt        = '0;
         for (int b = 0; b < SW_W; b++) m_sw_run[b] = -1;
         for (int b = 0; b < BTN_W; b++) m_btn_run[b] = -1;
         m_edge = 0;
      end else begin
         sw_d  = m_sw_q.pop_front();
         m_sw_q.push_back(sw_raw);
         btn_d = ~m_btn_q.pop_front();
         m_btn_q.push_back(btn_raw);
         prev  = m_btn_stable;
         for (int b = 0; b < SW_W; b++) begin
            if (sw_d[b] != m_sw_stable[b]) begin
               if (m_sw_run[b] < 0) m_sw_run[b] = m_edge;
               if (m_edge - m_sw_run[b] + 1 == DC) begin
                  m_sw_stable[b] = sw_d[b];
                  m_sw_run[b]    = -1;
               end
            end else m_sw_run[b] = -1;
         end
         for (int b = 0; b < BTN_W; b++) begin
            if (btn_d[b] != m_btn_stable[b]) begin
               if (m_btn_run[b] < 0) m_btn_run[b] = m_edge;
               if (m_edge - m_btn_run[b] + 1 == DC) begin
                  m_btn_stable[b] = btn_d[b];
                  m_btn_run[b]    = -1;
               end
            end else m_btn_run[b] = -1;
         end
         for (int b = 0; b < BTN_W; b++) begin
            if (!prev[b] && m_btn_stable[b]) m_evt[b] = 1'b1;
            else if (evt_clr[b])             m_evt[b] = 1'b0;
         end
         m_edge++;
      end
   end

   always_comb begin
      m_exp_sw               = 32'(m_sw_stable);
      m_exp_btn              = '0;
      m_exp_btn[BTN_W-1:0]   = m_btn_stable;
      m_exp_btn[4 +: BTN_W]  = m_evt;
   end

   task automatic test_reset();
      sw_raw  = '0;
      btn_raw = 4'hF;
      evt_clr = '0;
      rst_n   = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         checks++;
         if (io_sw !== 32'h0 || io_btn !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: sw=%h btn=%h want 0/0", i, io_sw, io_btn);
         end
         checks++;
         if (io_sw !== m_exp_sw || io_btn !== m_exp_btn) begin
            errors++;
            $display("FAIL reset_model cycle %0d: sw=%h btn=%h model %h/%h", i, io_sw, io_btn, m_exp_sw, m_exp_btn);
         end
      end
   endtask

   task automatic test_sw_latency();
      logic [31:0] want;
      @(negedge clk);
      sw_raw = 18'h2A5A5;
      for (int i = 0; i <= DC + 1; i++) begin
         @(posedge clk); #1;
         want = (i == DC + 1) ? 32'h0002A5A5 : 32'h0;
         checks++;
         if (io_sw !== want) begin
            errors++;
            $display("FAIL sw_latency edge k+%0d: got %h want %h", i, io_sw, want);
         end
         checks++;
         if (io_sw !== m_exp_sw) begin
            errors++;
            $display("FAIL sw_latency_model edge k+%0d: got %h model %h", i, io_sw, m_exp_sw);
         end
      end
   endtask

   task automatic test_glitch();
      @(negedge clk);
      sw_raw = '0;
      repeat (12) @(negedge clk);
      checks++;
      if (io_sw !== 32'h0) begin
         errors++;
         $display("FAIL glitch_settle: got %h want 0", io_sw);
      end
      sw_raw[0] = 1'b1;
      repeat (3) @(negedge clk);
      sw_raw[0] = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         checks++;
         if (io_sw !== 32'h0 || io_sw !== m_exp_sw) begin
            errors++;
            $display("FAIL glitch cycle %0d: got %h want 0 (model %h)", i, io_sw, m_exp_sw);
         end
      end
   endtask

   task automatic test_btn_press();
      logic [31:0] want;
      @(negedge clk);
      btn_raw = 4'b1101;
      for (int i = 0; i <= DC + 1; i++) begin
         @(posedge clk); #1;
         want = (i == DC + 1) ? 32'h22 : 32'h0;
         checks++;
         if (io_btn !== want || io_btn !== m_exp_btn) begin
            errors++;
            $display("FAIL btn_press edge k+%0d: got %h want %h (model %h)", i, io_btn, want, m_exp_btn);
         end
      end
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         checks++;
         if (io_btn !== 32'h22) begin
            errors++;
            $display("FAIL btn_hold cycle %0d: got %h want 22", i, io_btn);
         end
      end
      @(negedge clk);
      btn_raw = 4'hF;
      for (int i = 0; i <= DC + 1; i++) begin
         @(posedge clk); #1;
         want = (i == DC + 1) ? 32'h20 : 32'h22;
         checks++;
         if (io_btn !== want || io_btn !== m_exp_btn) begin
            errors++;
            $display("FAIL btn_release edge k+%0d: got %h want %h (model %h)", i, io_btn, want, m_exp_btn);
         end
      end
   endtask

   task automatic test_evt_clr();
      @(negedge clk);
      evt_clr = 4'b0010;
      @(posedge clk); #1;
      checks++;
      if (io_btn !== 32'h0) begin
         errors++;
         $display("FAIL evt_clear: got %h want 0", io_btn);
      end
      @(negedge clk);
      evt_clr = '0;
      btn_raw = 4'b1101;
      for (int i = 0; i < DC + 1; i++) begin
         @(posedge clk); #1;
         checks++;
         if (io_btn !== 32'h0 || io_btn !== m_exp_btn) begin
            errors++;
            $display("FAIL evt_repress edge k+%0d: got %h want 0 (model %h)", i, io_btn, m_exp_btn);
         end
      end
      @(negedge clk);
      evt_clr = 4'b0010;
      @(posedge clk); #1;
      checks++;
      if (io_btn !== 32'h22 || io_btn !== m_exp_btn) begin
         errors++;
         $display("FAIL evt_set_wins: got %h want 22 (model %h)", io_btn, m_exp_btn);
      end
      @(negedge clk);
      evt_clr = '0;
      btn_raw = 4'hF;
      repeat (DC + 4) @(negedge clk);
      checks++;
      if (io_btn !== 32'h20) begin
         errors++;
         $display("FAIL evt_sticky_after_release: got %h want 20", io_btn);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] want;
      @(negedge clk);
      sw_raw = 18'h8;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (io_sw !== 32'h0 || io_btn !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_drop: sw=%h btn=%h want 0/0", io_sw, io_btn);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i <= DC + 1; i++) begin
         @(posedge clk); #1;
         want = (i == DC + 1) ? 32'h8 : 32'h0;
         checks++;
         if (io_sw !== want || io_sw !== m_exp_sw) begin
            errors++;
            $display("FAIL mid_reset_relatch edge k+%0d: got %h want %h (model %h)", i, io_sw, want, m_exp_sw);
         end
      end
   endtask

   task automatic test_random();
      int hold;
      for (int seg = 0; seg < 400; seg++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0) sw_raw = SW_W'($urandom);
         else sw_raw[$urandom_range(0, SW_W - 1)] ^= 1'b1;
         if ($urandom_range(0, 2) == 0) btn_raw = BTN_W'($urandom);
         evt_clr = ($urandom_range(0, 4) == 0) ? BTN_W'($urandom) : '0;
         hold = $urandom_range(1, 10);
         for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            checks++;
            if (io_sw !== m_exp_sw) begin
               errors++;
               $display("FAIL rand_sw seg %0d: got %h model %h", seg, io_sw, m_exp_sw);
            end
            checks++;
            if (io_btn !== m_exp_btn) begin
               errors++;
               $display("FAIL rand_btn seg %0d: got %h model %h", seg, io_btn, m_exp_btn);
            end
            if (c == 0) begin
               @(negedge clk);
               evt_clr = '0;
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw_latency();
      test_glitch();
      test_btn_press();
      test_evt_clr();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
